// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores each word with its header flag, tracks
// packet boundaries on both sides, counts complete packets and flags header-sequence errors.
module router_pkt_fifo #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AFULL_TH = 14,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              pkt_last,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [PTR_W:0]    occupancy,
  output logic [PTR_W:0]    pkt_count,
  output logic              wr_err
);

  // Remaining-word counters hold payload_length + 1, which needs one bit more than the length field.
  localparam int REM_W = DATA_W - 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [REM_W-1:0]  wr_rem;
  logic [REM_W-1:0]  rd_rem;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W:0]   rd_word;
  logic              rd_hdr;
  logic              pkt_done;
  logic              pkt_drained;
  logic [REM_W-1:0]  wr_load;
  logic [REM_W-1:0]  rd_load;

  assign occupancy   = wr_ptr - rd_ptr;
  assign full        = (occupancy == (PTR_W+1)'(DEPTH));
  assign empty       = (occupancy == '0);
  assign almost_full = (occupancy >= (PTR_W+1)'(AFULL_TH));

  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr[PTR_W-1:0]];
  assign rd_hdr  = rd_word[DATA_W];

  assign wr_load = {1'b0, data_in[DATA_W-1:2]} + REM_W'(1);
  assign rd_load = {1'b0, rd_word[DATA_W-1:2]} + REM_W'(1);

  assign pkt_done    = wr_acc && !lfd_state && (wr_rem == REM_W'(1));
  assign pkt_drained = rd_acc && !rd_hdr && (rd_rem == REM_W'(1));

  // Storage has no reset; only locations behind wr_ptr are ever read.
  always_ff @(posedge clock) begin
    if (wr_acc && !soft_reset)
      mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_rem    <= '0;
      rd_rem    <= '0;
      pkt_count <= '0;
      wr_err    <= 1'b0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      pkt_last  <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_rem    <= '0;
      rd_rem    <= '0;
      pkt_count <= '0;
      wr_err    <= 1'b0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      pkt_last  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      pkt_last <= pkt_drained;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (lfd_state) begin
          if (wr_rem != '0) wr_err <= 1'b1;
          wr_rem <= wr_load;
        end else if (wr_rem == '0) begin
          wr_err <= 1'b1;
        end else begin
          wr_rem <= wr_rem - 1'b1;
        end
      end

      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_word[DATA_W-1:0];
        if (rd_hdr)
          rd_rem <= rd_load;
        else if (rd_rem != '0)
          rd_rem <= rd_rem - 1'b1;
      end

      // Completion and drain in the same cycle cancel; a stray drain never wraps the count.
      case ({pkt_done, pkt_drained})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   if (pkt_count != '0) pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_router_pkt_fifo;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 14;
  localparam int PTR_W    = $clog2(DEPTH);

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              soft_reset = 1'b0;
  logic              write_enb = 1'b0;
  logic              lfd_state = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read_enb = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              pkt_last;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [PTR_W:0]    occupancy;
  logic [PTR_W:0]    pkt_count;
  logic              wr_err;

  int checks = 0;
  int errors = 0;

  router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .rd_valid(rd_valid),
    .pkt_last(pkt_last), .full(full), .empty(empty), .almost_full(almost_full),
    .occupancy(occupancy), .pkt_count(pkt_count), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  // Model: each queued entry is {ends_packet, is_header, data}.
  logic [DATA_W+1:0] mq[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_rv = 1'b0;
  logic              m_last = 1'b0;
  logic              m_err = 1'b0;
  int                m_left = 0;

  function automatic int model_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i][DATA_W+1]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn || soft_reset) begin
        mq.delete();
        m_dout = '0; m_rv = 1'b0; m_last = 1'b0; m_err = 1'b0; m_left = 0;
      end else begin
        logic was_full, was_empty, ends;
        logic [DATA_W+1:0] e;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_rv = 1'b0;
        m_last = 1'b0;
        if (read_enb && !was_empty) begin
          e = mq.pop_front();
          m_dout = e[DATA_W-1:0];
          m_rv = 1'b1;
          m_last = e[DATA_W+1];
        end
        if (write_enb && !was_full) begin
          ends = 1'b0;
          if (lfd_state) begin
            if (m_left != 0) m_err = 1'b1;
            m_left = int'(data_in[DATA_W-1:2]) + 1;
          end else if (m_left == 0) begin
            m_err = 1'b1;
          end else begin
            m_left--;
            ends = (m_left == 0);
          end
          mq.push_back({ends, lfd_state, data_in});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("occupancy",   32'(occupancy),   32'(mq.size()));
      chk("empty",       32'(empty),       32'(mq.size() == 0));
      chk("full",        32'(full),        32'(mq.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL_TH));
      chk("pkt_count",   32'(pkt_count),   32'(model_pkts()));
      chk("wr_err",      32'(wr_err),      32'(m_err));
      chk("rd_valid",    32'(rd_valid),    32'(m_rv));
      chk("pkt_last",    32'(pkt_last),    32'(m_last));
      chk("data_out",    32'(data_out),    32'(m_dout));
    end
  end

  task automatic step(input logic we, input logic lfd, input logic [DATA_W-1:0] d, input logic re);
    write_enb = we; lfd_state = lfd; data_in = d; read_enb = re;
    @(posedge clock);
    #1;
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0;
  endtask

  task automatic write_big_pkt(input logic [DATA_W-1:0] base);
    step(1, 1, 8'h38, 0);
    for (int i = 1; i <= 14; i++) step(1, 0, base + 8'(i), 0);
    step(1, 0, 8'hAA, 0);
  endtask

  initial begin
    int last_cnt, last_idx;
    #1 resetn = 1'b0;
    #2;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_occ",   32'(occupancy), 32'd0);
    chk("reset_dout",  32'(data_out), 32'd0);
    chk("reset_pkts",  32'(pkt_count), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // 1: one 16-word packet fills the FIFO; 17th write dropped.
    step(1, 1, 8'h38, 0);
    for (int i = 1; i <= 12; i++) step(1, 0, 8'(i), 0);
    chk("t1_afull_13", 32'(almost_full), 32'd0);
    step(1, 0, 8'd13, 0);
    chk("t1_afull_14", 32'(almost_full), 32'd1);
    step(1, 0, 8'd14, 0);
    chk("t1_pkts_15", 32'(pkt_count), 32'd0);
    step(1, 0, 8'hAA, 0);
    chk("t1_full", 32'(full), 32'd1);
    chk("t1_occ",  32'(occupancy), 32'd16);
    chk("t1_pkts", 32'(pkt_count), 32'd1);
    step(1, 0, 8'h55, 0);
    chk("t1_drop_occ", 32'(occupancy), 32'd16);
    chk("t1_drop_err", 32'(wr_err), 32'd0);

    // 2: drain back-to-back; pkt_last only on the 16th word.
    last_cnt = 0; last_idx = -1;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 8'h00, 1);
      if (i == 0) chk("t2_first", 32'(data_out), 32'h38);
      if (rd_valid && pkt_last) begin last_cnt++; last_idx = i; end
    end
    chk("t2_last_dout", 32'(data_out), 32'hAA);
    chk("t2_last_cnt",  32'(last_cnt), 32'd1);
    chk("t2_last_idx",  32'(last_idx), 32'd15);
    chk("t2_empty",     32'(empty), 32'd1);
    chk("t2_pkts",      32'(pkt_count), 32'd0);
    step(0, 0, 8'h00, 1);
    chk("t2_rd_empty_valid", 32'(rd_valid), 32'd0);
    chk("t2_rd_empty_hold",  32'(data_out), 32'hAA);

    // 3: full with simultaneous read/write, then wrap.
    write_big_pkt(8'h40);
    step(1, 0, 8'h99, 1);
    chk("t3_full_rw_occ", 32'(occupancy), 32'd15);
    chk("t3_full_rw_dout", 32'(data_out), 32'h38);
    step(1, 1, 8'h01, 1);
    chk("t3_both_occ", 32'(occupancy), 32'd15);
    step(1, 0, 8'h5A, 0);
    chk("t3_pkts", 32'(pkt_count), 32'd2);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
    chk("t3_wrap_dout", 32'(data_out), 32'h5A);
    chk("t3_wrap_empty", 32'(empty), 32'd1);

    // 4: two minimal packets.
    step(1, 1, 8'h01, 0);
    step(1, 0, 8'hC1, 0);
    step(1, 1, 8'h01, 0);
    step(1, 0, 8'hC2, 0);
    chk("t4_pkts2", 32'(pkt_count), 32'd2);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("t4_last", 32'(pkt_last), 32'd1);
    chk("t4_pkts1", 32'(pkt_count), 32'd1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("t4_dout", 32'(data_out), 32'hC2);

    // 5: header arriving mid-packet raises sticky wr_err; soft_reset clears.
    step(1, 1, 8'h0C, 0);
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h12, 0);
    chk("t5_no_err", 32'(wr_err), 32'd0);
    step(1, 1, 8'h0C, 0);
    chk("t5_err", 32'(wr_err), 32'd1);
    step(1, 0, 8'h13, 0);
    chk("t5_err_sticky", 32'(wr_err), 32'd1);
    soft_reset = 1'b1;
    step(1, 0, 8'h14, 1);
    soft_reset = 1'b0;
    chk("t5_sr_err",   32'(wr_err), 32'd0);
    chk("t5_sr_empty", 32'(empty), 32'd1);
    chk("t5_sr_dout",  32'(data_out), 32'd0);
    chk("t5_sr_pkts",  32'(pkt_count), 32'd0);

    // 6: asynchronous reset mid-packet with 5 words stored.
    step(1, 1, 8'h38, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(8'h20 + i), 0);
    step(0, 0, 8'h00, 1);
    chk("t6_pre_occ",  32'(occupancy), 32'd5);
    chk("t6_pre_dout", 32'(data_out), 32'h38);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_occ",   32'(occupancy), 32'd0);
    chk("t6_async_empty", 32'(empty), 32'd1);
    chk("t6_async_dout",  32'(data_out), 32'd0);
    chk("t6_async_valid", 32'(rd_valid), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    step(1, 1, 8'h01, 0);
    step(1, 0, 8'h77, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("t6_post_dout", 32'(data_out), 32'h77);
    chk("t6_post_last", 32'(pkt_last), 32'd1);
    @(posedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware FIFO for the router output channels; one instance per destination port.
- Stores each word with its header flag (lfd_state).
- Tracks packet boundaries on both the write and read sides.
- Reports how many complete packets are buffered and pulses when a packet's last byte leaves.
- Sits between the router FSM/register block (writer) and the destination read interface; adds a programmable almost-full, packet counting and header-sequence error detection.

Parameters:
DATA_W, 8, data word width; header is {payload_length[DATA_W-1:2], address[1:0]}
DEPTH, 16, number of entries; power of two, at least 4
AFULL_TH, 14, occupancy at or above which almost_full asserts; range 1..DEPTH
PTR_W, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous clear (timeout from the router), active high
write_enb  in  1  write request
lfd_state  in  1  current write word is a header
data_in  in  DATA_W  write data
read_enb  in  1  read request
data_out  out  DATA_W  registered read data
rd_valid  out  1  data_out updated by an accepted read this cycle
pkt_last  out  1  with rd_valid: word is the final (parity) byte of a packet
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
almost_full  out  1  occupancy >= AFULL_TH
occupancy  out  PTR_W+1  words stored
pkt_count  out  PTR_W+1  complete packets stored (header..parity all written, not all read)
wr_err  out  1  sticky header-sequence error

Behaviour:
- Storage: DEPTH x (DATA_W+1) bits. Bit DATA_W holds lfd_state captured at write time.
- Pointers: wr_ptr and rd_ptr are PTR_W+1 bits with a wrap bit. occupancy = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- Write acceptance: write accepted iff write_enb && !full. When full, the write is dropped even if a read is accepted in the same cycle. No data is corrupted.
- Read acceptance: read accepted iff read_enb && !empty. When empty, the read is ignored, rd_valid=0 and data_out holds its value.
- Simultaneous accepted read and write: both pointers advance; occupancy unchanged.
- Read latency: 1 cycle. data_out and rd_valid are registered on the edge that accepts the read.
- Write-side packet tracking, on each accepted write:
  - lfd=1 loads wr_rem = payload_length + 1, counting payload plus parity.
  - Each accepted write with lfd=0 and wr_rem != 0 decrements wr_rem.
  - The write that takes wr_rem from 1 to 0 is the packet-complete event.
- Read-side packet tracking, on each accepted read:
  - A stored flag of 1 loads rd_rem = payload_length + 1 from that word.
  - Each later read with rd_rem != 0 decrements rd_rem.
  - The read taking rd_rem from 1 to 0 sets pkt_last=1 and is the packet-drained event.
- payload_length = 0: the packet is header + parity, two words.
- pkt_count:
  - +1 on packet-complete, -1 on packet-drained.
  - Both events in the same cycle leave it unchanged.
  - It never underflows.
- wr_err: set on an accepted write with lfd=1 while wr_rem != 0, or with lfd=0 while wr_rem == 0. The word is still stored; cleared only by reset or soft_reset.
- soft_reset (synchronous, highest priority over read/write that cycle): clears pointers, wr_rem, rd_rem, pkt_count and wr_err; sets rd_valid=0, pkt_last=0, data_out=0. Memory contents are not cleared.
- resetn low (asynchronous, immediate, independent of clock), including mid-packet:
  - all outputs 0 except empty=1;
  - all pointers, counters and flags 0.
- Reset deassertion takes effect on the next rising edge.
- Outputs full, empty, almost_full, occupancy and pkt_count are combinational from registered state; no X permitted after reset.

Test Plan:
1. Reset, then write header 0x38 (len 14, addr 0) + 14 payload + parity = 16 words -> full=1, almost_full=1, occupancy=16, pkt_count=1; a 17th write is dropped with occupancy still 16.
2. Read 16 words back-to-back -> data_out matches write order at 1-cycle latency; pkt_last=1 only on the 16th rd_valid; then empty=1, pkt_count=0.
3. Fill to 16, then assert read_enb and write_enb together -> read accepted, write dropped, occupancy=15. Next cycle with both asserted -> both accepted, occupancy stays 15; pointers wrap with data intact.
4. Write two packets with len 0 (header 0x01 + parity, twice) -> pkt_count=2. Read 2 words -> pkt_count=1, with pkt_last on word 2.
5. Write header 0x0C (len 3) then 2 payload, then a second header -> wr_err=1 and remains 1. soft_reset pulse -> wr_err=0, empty=1, data_out=0, pkt_count=0.
6. Drive resetn low asynchronously between clock edges mid-packet, with 5 words stored -> occupancy=0, empty=1, data_out=0 immediately before the next clock edge.
